// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver:
//   - state_t      : receiver FSM states
//   - PAR_*        : parity mode codes as presented on parity_mode
//   - STOP_*       : stop bit codes as presented on stop_bits
//   - maj3()       : 2-of-3 majority vote used by the optional majority
//                    sampler (macro UART_RX_MAJORITY_EN)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding received words with their error flags.
// The head entry is read straight from the storage registers, so a push into
// an empty FIFO becomes visible on the following clock (no fall-through).
// A push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   push_i   in   write wdata_i
//   wdata_i  in   entry to store
//   pop_i    in   remove the head entry
//   rdata_o  out  head entry (stable until popped)
//   full_o   out  all entries occupied
//   empty_o  out  no entries
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign do_pop_s  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// uart_rx_ovs
// Oversampling UART receiver with configurable word length (5..MAX_DATA_BITS),
// parity (none/odd/even/mark/space) and 1, 1.5 or 2 stop bits. Detects false
// starts, framing errors, parity errors and line breaks, and queues each word
// with its flags in a small FIFO behind a valid/ready interface.
//
// Optional macro UART_RX_MAJORITY_EN: each bit (start included) is the 2-of-3
// majority of rxs at tick SP-1, SP and SP+1, decided at SP+1. Undefined: a
// single sample at SP.
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous active-high reset
//   rx               in   asynchronous serial line, idle high
//   s_tick           in   OVS x baud enable pulse
//   data_bits        in   data bit count, clamped to 5..MAX_DATA_BITS
//   stop_bits        in   0: 1 stop, 1: 1.5 stop, 2/3: 2 stop
//   parity_mode      in   0 none, 1 odd, 2 even, 3 mark, 4 space, 5-7 none
//   dout             out  FIFO head word, right-justified
//   dout_parity_err  out  head word parity error
//   dout_frame_err   out  head word framing error
//   dout_break       out  head word is a line break
//   dout_valid       out  FIFO not empty
//   dout_ready       in   consumer takes the head word
//   overrun          out  one-clk pulse when a word is dropped (FIFO full)
//   busy             out  FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int OVS           = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     s_tick,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               stop_bits,
    input  logic [2:0]               parity_mode,
    output logic [MAX_DATA_BITS-1:0] dout,
    output logic                     dout_parity_err,
    output logic                     dout_frame_err,
    output logic                     dout_break,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overrun,
    output logic                     busy
);

    localparam int SP = OVS/2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int DP = SP + 1;
`else
    localparam int DP = SP;
`endif
    // The stop phase counts past OVS-1 (up to DP+OVS for two stop bits).
    localparam int S_W = $clog2(2*OVS);
    localparam int FW  = MAX_DATA_BITS + 3;

    // Line synchroniser and edge detector.
    logic rx_meta_q, rxs_q, rxs_prev_q;

    // FSM and frame datapath.
    state_t                   state_q, state_d;
    logic [S_W-1:0]           s_q, s_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [3:0]               nbits_q, nbits_d;
    logic [1:0]               stop_q, stop_d;
    logic [2:0]               par_q, par_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     perr_q, perr_d;
    logic                     zero_q, zero_d;
    logic                     overrun_q, overrun_d;

    logic                     fall_s;
    logic                     bit_s;
    logic                     par_exp_s;
    logic [3:0]               nbits_cfg_s;
    logic [2:0]               par_cfg_s;
    logic [S_W-1:0]           stop_end_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     full_s;
    logic                     empty_s;
    logic [FW-1:0]            wdata_s;
    logic [FW-1:0]            rdata_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] samp_q, samp_d;
    assign bit_s = maj3(samp_q[0], samp_q[1], rxs_q);
`else
    assign bit_s = rxs_q;
`endif

    assign fall_s = rxs_prev_q & ~rxs_q;

    // Frame configuration as it will be latched at the start edge.
    always_comb begin
        if (data_bits < 4'd5) begin
            nbits_cfg_s = 4'd5;
        end else if (data_bits > 4'(MAX_DATA_BITS)) begin
            nbits_cfg_s = 4'(MAX_DATA_BITS);
        end else begin
            nbits_cfg_s = data_bits;
        end
        if (parity_mode > PAR_SPACE) begin
            par_cfg_s = PAR_NONE;
        end else begin
            par_cfg_s = parity_mode;
        end
    end

    // Stop-phase tick offset at which the frame is finished.
    always_comb begin
        case (stop_q)
            STOP_1:   stop_end_s = S_W'(DP);
            STOP_1P5: stop_end_s = S_W'(DP + OVS/2);
            default:  stop_end_s = S_W'(DP + OVS);
        endcase
    end

    // Expected parity bit; unreceived upper data bits are zero and drop out.
    always_comb begin
        case (par_q)
            PAR_ODD:   par_exp_s = ~^data_q;
            PAR_EVEN:  par_exp_s = ^data_q;
            PAR_MARK:  par_exp_s = 1'b1;
            PAR_SPACE: par_exp_s = 1'b0;
            default:   par_exp_s = 1'b0;
        endcase
    end

    // Entry layout: {break, frame_err, parity_err, data}. A break always has
    // a low stop sample, so its frame error comes out set as well.
    assign wdata_s = {zero_q & ~bit_s, ~bit_s, perr_q, data_q};

    // Next-state and datapath logic for the receiver FSM.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_cnt_d = bit_cnt_q;
        nbits_d   = nbits_q;
        stop_d    = stop_q;
        par_d     = par_q;
        data_d    = data_q;
        perr_d    = perr_q;
        zero_d    = zero_q;
        push_s    = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        samp_d    = samp_q;
        if (s_tick && (s_q == S_W'(SP - 1))) begin
            samp_d[0] = rxs_q;
        end else begin
            samp_d[0] = samp_q[0];
        end
        if (s_tick && (s_q == S_W'(SP))) begin
            samp_d[1] = rxs_q;
        end else begin
            samp_d[1] = samp_q[1];
        end
`endif
        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d   = START;
                    s_d       = '0;
                    bit_cnt_d = 4'd0;
                    nbits_d   = nbits_cfg_s;
                    stop_d    = stop_bits;
                    par_d     = par_cfg_s;
                    data_d    = '0;
                    perr_d    = 1'b0;
                    zero_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if ((s_q == S_W'(DP)) && bit_s) begin
                        state_d = IDLE;   // line went back high: false start
                        s_d     = '0;
                    end else if (s_q == S_W'(OVS - 1)) begin
                        state_d = DATA;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVS - 1)) begin
                        s_d = '0;
                        if (bit_cnt_q == nbits_q - 4'd1) begin
                            bit_cnt_d = 4'd0;
                            state_d   = (par_q == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                        if (s_q == S_W'(DP)) begin
                            for (int i = 0; i < MAX_DATA_BITS; i++) begin
                                data_d[i] = (bit_cnt_q == 4'(i)) ? bit_s : data_q[i];
                            end
                            zero_d = zero_q & ~bit_s;
                        end else begin
                            data_d = data_q;
                        end
                    end
                end else begin
                    s_d = s_q;
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVS - 1)) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                        if (s_q == S_W'(DP)) begin
                            perr_d = (bit_s != par_exp_s);
                            zero_d = zero_q & ~bit_s;
                        end else begin
                            perr_d = perr_q;
                        end
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (s_tick) begin
                    s_d = s_q + S_W'(1);
                    if (s_q == S_W'(DP)) begin
                        push_s = 1'b1;
                        if (zero_q && !bit_s) begin
                            state_d = BRK_WAIT;
                            s_d     = '0;
                        end else if (stop_end_s == S_W'(DP)) begin
                            state_d = IDLE;
                            s_d     = '0;
                        end else begin
                            state_d = STOP;
                        end
                    end else if (s_q == stop_end_s) begin
                        state_d = IDLE;
                        s_d     = '0;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            BRK_WAIT: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = BRK_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop_s     = ~empty_s & dout_ready;
    assign overrun_d = push_s & full_s & ~pop_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchroniser, frame datapath and overrun pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            s_q        <= '0;
            bit_cnt_q  <= 4'd0;
            nbits_q    <= 4'd0;
            stop_q     <= 2'd0;
            par_q      <= 3'd0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            zero_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= 2'b00;
`endif
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            zero_q     <= zero_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= samp_d;
`endif
        end
    end

    uart_rx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (wdata_s),
        .pop_i   (pop_s),
        .rdata_o (rdata_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign dout            = rdata_s[MAX_DATA_BITS-1:0];
    assign dout_parity_err = rdata_s[MAX_DATA_BITS];
    assign dout_frame_err  = rdata_s[MAX_DATA_BITS+1];
    assign dout_break      = rdata_s[MAX_DATA_BITS+2];
    assign dout_valid      = ~empty_s;
    assign overrun         = overrun_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Parametrised UART receiver, successor to the fixed 7/8-bit receiver used in the stop-watch serial path.
- Configurable oversampling factor, 5..MAX_DATA_BITS data bits, five parity modes, and 1, 1.5 or 2 stop bits.
- Detects false starts, framing errors, parity errors and line breaks.
- Buffers received words with their error flags in a small FIFO behind a valid/ready interface, so the consumer no longer needs to catch a one-cycle done tick.

Parameters:
OVS, 16, s_tick pulses per bit period; even, >=8.
MAX_DATA_BITS, 9, widest supported data word (5..9).
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial line; idle high.
s_tick  in  1  baud-rate x OVS enable pulse, one clk wide.
data_bits  in  4  data bit count 5..MAX_DATA_BITS; values below 5 are used as 5, values above the maximum as MAX_DATA_BITS.
stop_bits  in  2  0 = 1 stop bit, 1 = 1.5, 2 or 3 = 2.
parity_mode  in  3  0 none, 1 odd, 2 even, 3 mark, 4 space; values 5-7 are treated as none.
dout  out  MAX_DATA_BITS  FIFO head word, right-justified, unused upper bits 0.
dout_parity_err  out  1  parity error flag of the head word.
dout_frame_err  out  1  framing error flag of the head word.
dout_break  out  1  break flag of the head word.
dout_valid  out  1  FIFO not empty.
dout_ready  in  1  consumer accepts the head word.
overrun  out  1  one-clk pulse when a completed word is dropped because the FIFO is full.
busy  out  1  high while the state machine is in any state other than IDLE.

Behaviour:
- rx passes through a 2-flop synchroniser. Both flops reset to 1. All internal logic uses the synchronised value rxs.
- Reset: state IDLE, FIFO empty, counters 0, and all outputs 0. Reset mid-frame discards the partial word.
- Tick counter s runs 0..OVS-1 per bit, advancing only on s_tick. Sample point is SP = OVS/2-1.
- IDLE: a falling edge on rxs clears s and the bit counter, latches data_bits, stop_bits and parity_mode for the frame, then enters START. Configuration changes mid-frame have no effect.
- START: at s==SP, rxs==1 is a false start: return to IDLE and push nothing. Otherwise continue; at s==OVS-1, clear s and enter DATA.
- DATA: sample at SP, LSB first, into the shift register. At s==OVS-1 of the last bit, enter PARITY if the mode is not none, else STOP.
- PARITY: sample at SP. The expected bit is: odd = ~^data, even = ^data, mark = 1, space = 0. A mismatch sets perr.
- STOP: at SP of the first stop bit, ferr = ~rxs. The word is assembled and pushed at this same tick. Return to IDLE at stop offset SP, SP+OVS/2 or SP+OVS for 1, 1.5 or 2 stop bits.
- Break: all data samples, the parity sample (if used) and the first stop sample are 0. The pushed entry has break=1 and ferr=1; perr is computed normally. The FSM enters BRK_WAIT, then goes to IDLE when rxs==1. No start is detected until that happens.
- FIFO push/pop:
  - Push at the STOP sample. Pop when dout_valid && dout_ready.
  - Push while full with a same-cycle pop: both happen, no overrun.
  - Push while full without a pop: word dropped, overrun=1 for 1 clk.
  - No fall-through: a push into an empty FIFO gives dout_valid on the next clk.
  - dout and the flags are stable while dout_valid && !dout_ready.
- Latency: the last stop-bit sample tick to dout_valid is 1 clk when the FIFO is empty.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit, including start, is the 2-of-3 majority of rxs at s = SP-1, SP and SP+1. The decision is made at SP+1.
- Undefined: single sample at SP.
- Frame timing and state transitions are otherwise identical.

Decomposition:
- uart_pkg holds the state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), the parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE) and the stop code constants.
- One sub-module, uart_rx_fifo: synchronous FIFO of width MAX_DATA_BITS+3 and depth FIFO_DEPTH, with push, pop, full, empty and same-cycle push/pop support.

Test Plan:
- 8N1, OVS=16, byte 0xA5 -> one entry dout=0x0A5, all flags 0, dout_valid 1 clk after the stop sample.
- 7E1 frame data 0x41 with the parity bit deliberately 1 -> dout=0x041, dout_parity_err=1, dout_frame_err=0.
- rx low pulse of 5 ticks, then high -> false start, no push, busy returns to 0 within SP+1 ticks of the falling edge.
- rx held low for 3 frame times, then released -> exactly one entry dout=0, dout_break=1, dout_frame_err=1; the FSM stays in BRK_WAIT until rx rises; a following 0x55 frame is received clean.
- FIFO_DEPTH=4, dout_ready=0, send 5 frames -> 4 entries retained in order, overrun pulses once on the 5th; then draining with ready=1 yields 4 pops.
- 9 data bits, mark parity, 2 stop bits, data 0x1FF -> dout=0x1FF, no errors; stop_bits=1 (1.5 stop) back-to-back frames are all received.
